// File: rtl/sm_arith_select_if.sv
// Bundle of button, operand and display signals between the debouncer side
// and the sign-magnitude arithmetic/display selector.
interface sm_arith_select_if #(
  parameter int W = 8
);
  logic [3:0]   btn;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] mag;
  logic         sign;
  logic [1:0]   sel;
  logic         op_sub;
  logic         ovf;
  logic         blank;

  // Stimulus side: drives buttons and operands, observes the display.
  modport master (
    output btn, a, b,
    input  mag, sign, sel, op_sub, ovf, blank
  );

  // The arithmetic/select block itself.
  modport slave (
    input  btn, a, b,
    output mag, sign, sel, op_sub, ovf, blank
  );
endinterface

// File: rtl/sm_arith_select.sv
// Sign-magnitude add/subtract unit with button-driven display selection.
// Buttons pick which value (A, B or the registered result) is presented on
// mag/sign; btn[3] toggles add/sub. An overflowed result shown on the display
// is signalled by a blinking blank strobe.
module sm_arith_select #(
  parameter int W         = 8,
  parameter int BLINK_DIV = 25_000_000
) (
  input logic              clk,
  input logic              reset,
  sm_arith_select_if.slave bus
);

  localparam int CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_DIV - 1);

  typedef enum logic [1:0] {
    SHOW_A   = 2'b00,
    SHOW_B   = 2'b01,
    SHOW_RES = 2'b10
  } state_t;

  state_t       state_reg;
  logic         op_sub_reg;
  logic [3:0]   btn_q_reg;
  logic [3:0]   rise_reg;

  logic [W-2:0] res_mag_reg;
  logic         res_sign_reg;
  logic         ovf_reg;

  logic [W-1:0] mag_reg;
  logic         sign_reg;

  logic [CW-1:0] cnt_reg;
  logic          blank_reg;

  // Combinational arithmetic
  logic [W-2:0] ma;
  logic [W-2:0] mb;
  logic         sa;
  logic         sb_eff;
  logic [W-1:0] sum;
  logic [W-2:0] res_mag_next;
  logic         res_sign_next;
  logic         res_ovf_next;

  assign ma     = bus.a[W-2:0];
  assign mb     = bus.b[W-2:0];
  assign sa     = bus.a[W-1];
  assign sb_eff = bus.b[W-1] ^ op_sub_reg;
  assign sum    = {1'b0, ma} + {1'b0, mb};

  // Register the button levels and the rises they produce, so a rise is acted
  // on one edge after it is detected.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_q_reg <= '0;
      rise_reg  <= '0;
    end else begin
      btn_q_reg <= bus.btn;
      rise_reg  <= bus.btn & ~btn_q_reg;
    end
  end

  // Selection FSM and add/sub mode; result has priority over B over A.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= SHOW_A;
      op_sub_reg <= 1'b0;
    end else begin
      if (rise_reg[2]) begin
        state_reg <= SHOW_RES;
      end else if (rise_reg[1]) begin
        state_reg <= SHOW_B;
      end else if (rise_reg[0]) begin
        state_reg <= SHOW_A;
      end
      if (rise_reg[3]) begin
        op_sub_reg <= ~op_sub_reg;
      end
    end
  end

  // Sign-magnitude add/subtract; zero magnitude always reported as positive.
  always_comb begin
    res_mag_next  = '0;
    res_sign_next = 1'b0;
    res_ovf_next  = 1'b0;
    if (sa == sb_eff) begin
      res_mag_next  = sum[W-2:0];
      res_ovf_next  = sum[W-1];
      res_sign_next = sa;
    end else if (ma >= mb) begin
      res_mag_next  = ma - mb;
      res_sign_next = sa;
    end else begin
      res_mag_next  = mb - ma;
      res_sign_next = sb_eff;
    end
    if (res_mag_next == '0) begin
      res_sign_next = 1'b0;
    end
  end

  // Capture the arithmetic result and its overflow flag every cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      res_mag_reg  <= '0;
      res_sign_reg <= 1'b0;
      ovf_reg      <= 1'b0;
    end else begin
      res_mag_reg  <= res_mag_next;
      res_sign_reg <= res_sign_next;
      ovf_reg      <= res_ovf_next;
    end
  end

  // Display register: raw operand or the registered result, per selection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mag_reg  <= '0;
      sign_reg <= 1'b0;
    end else begin
      case (state_reg)
        SHOW_A: begin
          mag_reg  <= {1'b0, bus.a[W-2:0]};
          sign_reg <= bus.a[W-1];
        end
        SHOW_B: begin
          mag_reg  <= {1'b0, bus.b[W-2:0]};
          sign_reg <= bus.b[W-1];
        end
        default: begin
          mag_reg  <= {1'b0, res_mag_reg};
          sign_reg <= res_sign_reg;
        end
      endcase
    end
  end

  // Blink strobe runs only while an overflowed result is on display.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_reg   <= '0;
      blank_reg <= 1'b0;
    end else if (state_reg == SHOW_RES && ovf_reg) begin
      if (cnt_reg == CNT_LAST) begin
        cnt_reg   <= '0;
        blank_reg <= ~blank_reg;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end else begin
      cnt_reg   <= '0;
      blank_reg <= 1'b0;
    end
  end

  assign bus.mag    = mag_reg;
  assign bus.sign   = sign_reg;
  assign bus.sel    = state_reg;
  assign bus.op_sub = op_sub_reg;
  assign bus.ovf    = ovf_reg;
  assign bus.blank  = blank_reg;

endmodule

// File: doc/sm_arith_select.md
Name: sm_arith_select

Overview:
- Parametrised sign-magnitude add/subtract unit with button-driven display selection; the next generation of the board-level adder top.
- Registers the operands' result, tracks which value is shown, and toggles add/sub mode.
- Flags magnitude overflow and drives a blink-blank strobe.
- Sits between the button debouncer and the hex/seven-segment controller, and feeds that controller's mag/sign inputs.

Parameters:
- W, 8, total word width including sign bit (sign = MSB, magnitude = W-1 bits); W >= 3.
- BLINK_DIV, 25_000_000, clk cycles per blank half-period while an overflowed result is displayed; >= 2.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, asynchronous active-low reset.
- btn, input, 4, debounced button levels: [0] show A, [1] show B, [2] show result, [3] toggle add/sub.
- a, input, W, operand A, sign-magnitude.
- b, input, W, operand B, sign-magnitude.
- mag, output, W, displayed magnitude zero-extended: {1'b0, magnitude[W-2:0]}.
- sign, output, 1, displayed sign; 1 = negative.
- sel, output, 2, current display selection: 00 = A, 01 = B, 10 = result.
- op_sub, output, 1, 1 = result is A - B; 0 = result is A + B.
- ovf, output, 1, registered result overflowed.
- blank, output, 1, display blank strobe.

Behaviour:
- Reset (reset = 0, async) clears:
  - sel = 00, op_sub = 0.
  - result register = +0, ovf = 0.
  - mag = 0, sign = 0, blank = 0.
  - blink counter = 0.
  - edge-detect history = 0.
- Edge detect: btn is registered each cycle into btn_q. A rise is btn & ~btn_q. A rise sampled at edge n takes effect at edge n+1. Held buttons do not retrigger.
- Selection FSM, states SHOW_A, SHOW_B, SHOW_RES:
  - A rise on [0], [1] or [2] moves to the corresponding state from any state.
  - Simultaneous rises resolve with priority [2] > [1] > [0].
  - With no rise the state holds; there is no latching of undefined cases.
- Mode: a rise on btn[3] toggles op_sub. It may coincide with a selection rise; both take effect on the same edge.
- Arithmetic, combinational from a, b and op_sub, captured into the result register every cycle:
  - Effective B sign is b[W-1] ^ op_sub.
  - Same effective signs: magnitude = ma + mb, computed W bits wide. ovf = carry into bit W-1. Result magnitude = low W-1 bits. Sign = sign of A.
  - Different signs: larger magnitude minus smaller. Sign = sign of the larger. ovf = 0.
  - Zero result in any case is forced to sign 0 (no negative zero). Negative-zero inputs therefore never produce sign = 1 with magnitude 0.
- Output register, updated every cycle from the state:
  - SHOW_A: {0, a[W-2:0]}, sign a[W-1].
  - SHOW_B: {0, b[W-2:0]}, sign b[W-1] (raw, unaffected by op_sub).
  - SHOW_RES: result register.
- Latency:
  - Operand change -> result register: 1 cycle.
  - Operand change -> mag/sign in SHOW_RES: 2 cycles.
  - Button rise at input -> sel changes after 2 edges -> mag/sign change 1 edge later.
- ovf output is the registered flag of the current result. It is independent of sel.
- Blink:
  - While sel = 10 and ovf = 1, the counter runs 0 .. BLINK_DIV-1 and blank toggles on wrap.
  - Otherwise the counter is held at 0 and blank = 0 on the next edge.
  - On re-entry, blinking restarts with blank = 0.
- Reset mid-operation (any state, any count) returns all of the above to reset values immediately. First valid rise detection is on the second edge after release.

Test Plan:
- W = 8, reset, then a = 0x05, b = 0x83 (+5 + -3), btn[2] pulse -> sel = 10, mag = 0x02, sign = 0, ovf = 0.
- Same operands, btn[3] pulse (sub) -> op_sub = 1, mag = 0x08, sign = 0. Second btn[3] pulse -> back to 0x02.
- a = 0x64, b = 0x64 (+100 + +100), SHOW_RES, BLINK_DIV = 4 -> ovf = 1, mag = 0x48, sign = 0, blank toggles every 4 cycles. btn[0] -> blank = 0, counter frozen, mag = 0x64.
- Zero handling:
  - a = 0x05, b = 0x85 -> result mag = 0, sign = 0.
  - a = 0x80, b = 0x80 -> mag = 0, sign = 0.
  - a = 0x85, b = 0x05 with op_sub = 1 -> mag = 0x0A, sign = 1.
- Buttons:
  - btn[0] and btn[2] rise on the same cycle -> sel = 10.
  - btn[1] held 20 cycles -> single transition only.
  - sel = 01 shows b = 0x83 as mag = 0x03, sign = 1.
- Assert reset mid-blink (ovf = 1, counter = 2) -> all outputs 0 asynchronously. After release with the same operands, sel = 00 and mag = a within 1 cycle.
